// File: rtl/regfile_sb.sv
// Register file with two bypassed operand ports, a raw debug port, two
// prioritised write-back ports and a per-register pending scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic              rd0_busy,
  output logic              rd1_busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [ADDR_W:0]   pend_cnt_reg;
  logic [ADDR_W:0]   pend_cnt_next;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Issue beats a same-cycle write-back: the new producer supersedes the old one.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
    if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
      assign pending_next[gi] = 1'b0;
    end else begin : g_norm
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      logic iss_hit;
      logic wb_clr;
      assign iss_hit = iss && (iss_addr == IDX);
      assign wb_clr  = (we0 && (wa0 == IDX)) || (we1 && (wa1 == IDX));
      assign pending_next[gi] = flush   ? 1'b0 :
                                iss_hit ? 1'b1 :
                                wb_clr  ? 1'b0 : pending_reg[gi];
    end
  end

  always_comb begin
    pend_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_next = pend_cnt_next + (ADDR_W+1)'(pending_next[i]);
    end
  end

  // Port 0 is written last so it wins a same-address double write-back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
    end else begin
      if (we1 && !is_zero(wa1)) mem_reg[wa1] <= wd1;
      if (we0 && !is_zero(wa0)) mem_reg[wa0] <= wd0;
      pending_reg  <= pending_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;
    logic [DATA_W-1:0] rd_val;
    logic              busy_val;

    assign ra   = (gi == 0) ? ra0 : ra1;
    assign hit0 = we0 && (wa0 == ra);
    assign hit1 = we1 && (wa1 == ra);

    always_comb begin
      rd_val = mem_reg[ra];
      if (hit0) begin
        rd_val = wd0;
      end else if (hit1) begin
        rd_val = wd1;
      end
      if (!rstn || is_zero(ra)) begin
        rd_val = '0;
      end
    end

    assign busy_val = rstn && pending_reg[ra] && !(hit0 || hit1);
  end

  assign rd0      = g_rd[0].rd_val;
  assign rd1      = g_rd[1].rd_val;
  assign rd0_busy = g_rd[0].busy_val;
  assign rd1_busy = g_rd[1].busy_val;
  assign dbg_data = rstn ? mem_reg[dbg_addr] : '0;
  assign pend_cnt = pend_cnt_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against an array/bit-vector
// reference model of the register file and scoreboard.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] ra0, ra1, dbg_addr, wa0, wa1, iss_addr;
  logic [DW-1:0] rd0, rd1, dbg_data, wd0, wd1;
  logic          rd0_busy, rd1_busy, we0, we1, iss, flush;
  logic [AW:0]   pend_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_mem [N];
  bit            m_pend [N];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rstn(rstn),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1),
    .rd0_busy(rd0_busy), .rd1_busy(rd1_busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss(iss), .iss_addr(iss_addr), .flush(flush),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == '0) return '0;
    if (we0 && wa0 == a) return wd0;
    if (we1 && wa1 == a) return wd1;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return (a != '0) && m_pend[a] && !((we0 && wa0 == a) || (we1 && wa1 == a));
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (we1 && wa1 != '0) m_mem[wa1] = wd1;
    if (we0 && wa0 != '0) m_mem[wa0] = wd0;
    if (flush) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      if (we0) m_pend[wa0] = 1'b0;
      if (we1) m_pend[wa1] = 1'b0;
      if (iss && iss_addr != '0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss = 1'b0; flush = 1'b0;
  endtask

  // Check every output against the model, then take one clock edge.
  task automatic step();
    #2;
    check("rd0", rd0, exp_rd(ra0));
    check("rd1", rd1, exp_rd(ra1));
    check("rd0_busy", 32'(rd0_busy), 32'(exp_busy(ra0)));
    check("rd1_busy", 32'(rd1_busy), 32'(exp_busy(ra1)));
    check("dbg_data", dbg_data, m_mem[dbg_addr]);
    check("pend_cnt", 32'(pend_cnt), 32'(exp_cnt()));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    idle();
    ra0 = 5'd5; ra1 = '0; dbg_addr = '0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;

    #3;
    check("reset_rd0", rd0, 32'h0);
    check("reset_busy", 32'(rd0_busy), 32'h0);
    check("reset_cnt", 32'(pend_cnt), 32'h0);
    #5 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Bypass
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h12345678; ra0 = 5'd3; dbg_addr = 5'd3;
    #1;
    check("bypass_rd0", rd0, 32'h12345678);
    check("bypass_dbg_old", dbg_data, 32'h0);
    step(); idle();
    #1 check("bypass_dbg_new", dbg_data, 32'h12345678);

    // Port conflict
    we0 = 1'b1; we1 = 1'b1; wa0 = 5'd7; wa1 = 5'd7;
    wd0 = 32'hAAAA0000; wd1 = 32'h00005555; ra1 = 5'd7;
    #1 check("conflict_comb", rd1, 32'hAAAA0000);
    step(); idle();
    #1 check("conflict_stored", rd1, 32'hAAAA0000);

    // Scoreboard
    iss = 1'b1; iss_addr = 5'd4; ra0 = 5'd4;
    #1 check("iss_no_early_busy", 32'(rd0_busy), 32'h0);
    step(); idle();
    #1;
    check("iss_busy", 32'(rd0_busy), 32'h1);
    check("iss_cnt", 32'(pend_cnt), 32'h1);
    we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000BEEF;
    #1 check("wb_clears_busy", 32'(rd0_busy), 32'h0);
    step(); idle();
    #1 check("wb_cnt", 32'(pend_cnt), 32'h0);
    iss = 1'b1; iss_addr = 5'd4; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000CAFE;
    step(); idle();
    #1;
    check("iss_wb_cnt", 32'(pend_cnt), 32'h1);
    check("iss_wb_busy", 32'(rd0_busy), 32'h1);
    check("iss_wb_data", rd0, 32'h0000CAFE);

    // Zero register
    iss = 1'b1; iss_addr = 5'd0; ra0 = 5'd0;
    step(); idle();
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
    #1;
    check("zero_rd0", rd0, 32'h0);
    check("zero_busy", 32'(rd0_busy), 32'h0);
    step(); idle();
    #1;
    check("zero_cnt", 32'(pend_cnt), 32'h1);
    check("zero_rd0_after", rd0, 32'h0);

    // Flush and count
    for (int i = 1; i < N; i++) begin
      iss = 1'b1; iss_addr = AW'(i);
      step();
    end
    idle();
    check("full_cnt", 32'(pend_cnt), 32'd31);
    flush = 1'b1; iss = 1'b1; iss_addr = 5'd9; ra0 = 5'd9;
    step(); idle();
    #1;
    check("flush_cnt", 32'(pend_cnt), 32'h0);
    check("flush_busy", 32'(rd0_busy), 32'h0);

    // Asynchronous reset mid-operation
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; iss = 1'b1; iss_addr = 5'd6;
    step(); idle();
    ra0 = 5'd5;
    #1 check("pre_reset_rd0", rd0, 32'hDEADBEEF);
    rstn = 1'b0;
    #1;
    check("async_reset_rd0", rd0, 32'h0);
    check("async_reset_cnt", 32'(pend_cnt), 32'h0);
    model_reset();
    rstn = 1'b1;
    #1;
    check("post_reset_dbg", dbg_data, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      we0 = ($urandom_range(0, 2) == 0);
      we1 = ($urandom_range(0, 2) == 0);
      wa0 = AW'($urandom_range(0, N-1));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, N-1));
      wd0 = $urandom;
      wd1 = $urandom;
      iss = ($urandom_range(0, 1) == 0);
      iss_addr = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, N-1));
      flush = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 2))
        0: ra0 = wa0;
        1: ra0 = wa1;
        default: ra0 = AW'($urandom_range(0, N-1));
      endcase
      ra1 = ($urandom_range(0, 1) == 0) ? wa1 : AW'($urandom_range(0, N-1));
      dbg_addr = ($urandom_range(0, 1) == 0) ? wa0 : AW'($urandom_range(0, N-1));
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with integrated hazard scoreboard for the pipelined CPU. It provides two operand read ports plus a debug read port, two write-back ports with fixed priority, write-first bypass, and a per-register pending bit. The decode stage uses the pending bits to stall on outstanding writes, and the debug port feeds the board display.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W registers
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes, and is never pending
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- ra0, ra1  in  ADDR_W  operand read addresses
- rd0, rd1  out  DATA_W  operand read data (combinational)
- rd0_busy, rd1_busy  out  1  pending bit of ra0/ra1 after same-cycle clear (combinational)
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (no bypass, array contents only)
- we0, wa0, wd0  in  1/ADDR_W/DATA_W  write-back port 0 (high priority)
- we1, wa1, wd1  in  1/ADDR_W/DATA_W  write-back port 1
- iss  in  1  issue: mark iss_addr pending at this edge
- iss_addr  in  ADDR_W  destination of issued instruction
- flush  in  1  clear all pending bits at this edge
- pend_cnt  out  ADDR_W+1  number of registers currently pending (registered)

## Operation
- Reset (rstn=0, asynchronous): all registers 0, all pending bits 0, pend_cnt=0. While rstn=0 all writes, issues, and bypasses are suppressed; rd0/rd1/dbg_data read 0 and busy outputs read 0.
- Write: at a rising edge with weN=1, register waN <= wdN. If we0 and we1 target the same address, port 0 data is stored.
- ZERO_REG=1: writes and issues to address 0 are dropped; reads of address 0 return 0 on every port; rdX_busy for address 0 is 0.
- Read bypass (rd0/rd1 only): if ra matches wa0 with we0=1, return wd0. Else if ra matches wa1 with we1=1, return wd1. Else return the array value. dbg_data never bypasses.
- Pending set/clear, evaluated per register at each edge, in descending priority:
  - flush=1 → all bits 0; iss is ignored that cycle.
  - iss=1 and iss_addr=r → bit r = 1. This wins over a same-cycle write-back to r, because the new producer supersedes the old one.
  - (we0 and wa0=r) or (we1 and wa1=r) → bit r = 0.
  - otherwise hold.
- Busy output: rdX_busy = pending[raX] AND NOT (a same-cycle write-back to raX). A same-cycle iss does not raise busy until the next cycle.
- pend_cnt is updated at each edge to the population count of the next pending vector. It saturates naturally at 2^ADDR_W (or 2^ADDR_W−1 when ZERO_REG=1) and never wraps.

## Timing
- Read latency 0 cycles (combinational from address and write inputs). Write-to-array latency is 1 edge.
- Bypass makes a write-back visible on rd0/rd1 in the same cycle. The array holds the value from the following cycle.
- Pending bits and pend_cnt change only on rising edges, or asynchronously on reset.
- Reset asserted mid-operation clears all state immediately. The first write after release takes effect at the first rising edge with rstn=1.
- Issue and write-back to the same register in the same cycle: data is written and the bit ends at 1.
- Double write-back to the same address: port 0 data is stored and the bit is cleared.

## Test plan
- Reset: write 0xDEADBEEF to r5, pulse rstn low asynchronously between edges → rd0 (ra0=5) = 0 immediately; pend_cnt = 0.
- Bypass: we0=1, wa0=3, wd0=0x12345678, ra0=3 in the same cycle → rd0 = 0x12345678 before the edge; dbg_data (dbg_addr=3) = old value (0); after the edge dbg_data = 0x12345678.
- Port conflict: we0=we1=1, wa0=wa1=7, wd0=0xAAAA0000, wd1=0x5555 → rd1 (ra1=7) = 0xAAAA0000 combinationally and after the edge.
- Scoreboard: issue r4 → next cycle rd0_busy=1 (ra0=4), pend_cnt=1. Write back r4 → rd0_busy=0 in that cycle; after the edge pend_cnt=0. Issue r4 together with write-back r4 → bit stays 1, pend_cnt=1.
- Zero register (ZERO_REG=1): iss with iss_addr=0, then we1=1, wa1=0, wd1=0xFFFFFFFF → rd0 (ra0=0) = 0, rd0_busy = 0, pend_cnt unchanged.
- Flush and count: issue r1..r31 on consecutive cycles → pend_cnt = 31. Assert flush together with iss on r9 → all bits clear and pend_cnt = 0 next cycle.
